// File: rtl/lfsr_pkg.sv
// lfsr_pkg: XNOR tap table and request FSM states shared by the LFSR blocks
package lfsr_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, HOLD} rr_state_t;
  // Maximal-length XNOR taps, bit i set means q[i] feeds the XNOR
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/lfsr_rand_range_core.sv
// lfsr_core: XNOR Fibonacci LFSR with seed load; all-ones seeds load zero to avoid lock-up
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load;
  logic             w_fb;
  assign w_fb   = ~^(r_q & TAPS);
  assign w_load = &load_val ? '0 : load_val;
  assign q      = r_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= '0;
    else if (load) r_q <= w_load;
    else if (advance) r_q <= {r_q[WIDTH-2:0], w_fb};
  end
endmodule

// File: rtl/lfsr_rand_range.sv
// lfsr_rand_range: LFSR-backed random source returning values in 0..LIMIT-1 over valid/ready,
// rejecting out-of-range states by re-sampling the sequence.
module lfsr_rand_range
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int LIMIT = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic [WIDTH-1:0] rand_out,
  output logic [WIDTH-1:0] lfsr_q
);
  if (WIDTH < 3 || WIDTH > 16 || LIMIT < 1 || LIMIT > (1 << WIDTH)) begin : g_bad_param
    $error("lfsr_rand_range: unsupported WIDTH/LIMIT");
  end
  rr_state_t        r_state;
  rr_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic             w_hit;
  logic             w_accept;
  logic             w_advance;
  lfsr_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .advance  (w_advance),
    .load     (seed_load),
    .load_val (seed),
    .q        (lfsr_q)
  );
  // One extra bit so LIMIT = 2**WIDTH accepts every state
  assign w_hit     = {1'b0, lfsr_q} < (WIDTH+1)'(LIMIT);
  assign w_advance = en | (r_state == SEARCH);
  always_comb begin
    w_accept    = (r_state == SEARCH) && w_hit;
    w_state_nxt = (r_state == IDLE)   ? (req ? SEARCH : IDLE) :
                  (r_state == SEARCH) ? (w_hit ? HOLD : SEARCH) :
                  (rand_ready ? (req ? SEARCH : IDLE) : HOLD);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_out <= lfsr_q;
    end
  end
  assign rand_valid = (r_state == HOLD);
  assign rand_out   = r_out;
endmodule

// File: tb/tb_lfsr_rand_range.sv
// tb_lfsr_rand_range: directed vector table plus hand sequences for period, HOLD and reset cases
module tb_lfsr_rand_range;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, seed_load = 1'b0, req = 1'b0, rand_ready = 1'b0;
  logic [5:0] seed = '0;
  logic       rand_valid, e_valid;
  logic [5:0] rand_out, lfsr_q, e_out, e_q;
  int         tests = 0;
  int         fails = 0;
  always #5 clk = ~clk;
  lfsr_rand_range #(.WIDTH(6), .LIMIT(40)) u_dut (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed), .req(req),
    .rand_valid(rand_valid), .rand_ready(rand_ready), .rand_out(rand_out), .lfsr_q(lfsr_q)
  );
  // Boundary instance: 47 is exactly LIMIT here and must be rejected
  lfsr_rand_range #(.WIDTH(6), .LIMIT(47)) u_edge (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed), .req(req),
    .rand_valid(e_valid), .rand_ready(rand_ready), .rand_out(e_out), .lfsr_q(e_q)
  );
  typedef struct packed {
    logic       en, ld;
    logic [5:0] seed;
    logic       req, rdy;
    logic [5:0] q;
    logic       v;
    logic [5:0] o;
    logic       co;
  } vec_t;
  function automatic vec_t mk(int e, int l, int s, int r, int y, int q, int v, int o, int co);
    return '{1'(e), 1'(l), 6'(s), 1'(r), 1'(y), 6'(q), 1'(v), 6'(o), 1'(co)};
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic tick(input logic e, input logic l, input logic [5:0] s, input logic r, input logic y);
    en = e; seed_load = l; seed = s; req = r; rand_ready = y;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    en = 0; seed_load = 0; seed = '0; req = 0; rand_ready = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  vec_t       tbl[20];
  logic [63:0] seen;
  int         bad, n;
  initial begin
    tbl[0]  = mk(1,0,0, 0,0,  1,0,0,1);
    tbl[1]  = mk(1,0,0, 0,0,  3,0,0,1);
    tbl[2]  = mk(1,0,0, 0,0,  7,0,0,1);
    tbl[3]  = mk(1,0,0, 0,0, 15,0,0,1);
    tbl[4]  = mk(1,0,0, 0,0, 31,0,0,1);
    tbl[5]  = mk(1,0,0, 0,0, 62,0,0,1);
    tbl[6]  = mk(1,0,0, 0,0, 61,0,0,1);
    tbl[7]  = mk(0,1,62,0,0, 62,0,0,1);
    tbl[8]  = mk(0,0,0, 1,0, 62,0,0,1);
    tbl[9]  = mk(0,0,0, 0,0, 61,0,0,1);
    tbl[10] = mk(0,0,0, 0,0, 59,0,0,1);
    tbl[11] = mk(0,0,0, 0,0, 55,0,0,1);
    tbl[12] = mk(0,0,0, 0,0, 47,0,0,1);
    tbl[13] = mk(0,0,0, 0,0, 30,0,0,1);
    tbl[14] = mk(0,0,0, 0,0, 60,1,30,1);
    tbl[15] = mk(0,0,0, 0,0, 60,1,30,1);
    tbl[16] = mk(0,1,63,0,0,  0,1,30,1);
    tbl[17] = mk(1,0,0, 0,0,  1,1,30,1);
    tbl[18] = mk(0,0,0, 0,1,  1,0,0,0);
    tbl[19] = mk(0,0,0, 0,1,  1,0,0,0);
    #12;
    chk("reset_q", lfsr_q, 0);
    chk("reset_valid", rand_valid, 0);
    chk("reset_out", rand_out, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].en, tbl[i].ld, tbl[i].seed, tbl[i].req, tbl[i].rdy);
      chk($sformatf("vec%0d_q", i), lfsr_q, tbl[i].q);
      chk($sformatf("vec%0d_valid", i), rand_valid, tbl[i].v);
      chk($sformatf("vec%0d_edge_valid", i), e_valid, tbl[i].v);
      if (tbl[i].co) begin
        chk($sformatf("vec%0d_out", i), rand_out, tbl[i].o);
        chk($sformatf("vec%0d_edge_out", i), e_out, tbl[i].o);
      end
    end
    // Full period from reset: 63 distinct states, never all-ones, back to zero
    do_reset();
    seen = '0;
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      tick(1, 0, 0, 0, 0);
      if (lfsr_q == 6'd63 || seen[lfsr_q]) bad++;
      seen[lfsr_q] = 1'b1;
    end
    chk("period_unique", bad, 0);
    chk("period_count", $countones(seen), 63);
    chk("period_wrap", lfsr_q, 0);
    // HOLD stability, then back-to-back request from HOLD
    do_reset();
    tick(0, 1, 62, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 0, 0, 1, 0);
    chk("hold_enter_out", rand_out, 30);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1, 0);
      chk("hold_stable", {rand_valid, rand_out, lfsr_q}, {1'b1, 6'd30, 6'd60});
    end
    tick(0, 0, 0, 1, 1);
    chk("b2b_valid_drop", rand_valid, 0);
    n = 0;
    while (!rand_valid && n < 70) begin
      tick(0, 0, 0, 1, 0);
      n++;
    end
    chk("b2b_edges", n, 4);
    chk("b2b_out", rand_out, 39);
    chk("b2b_in_range", int'(rand_out < 6'd40), 1);
    tick(0, 0, 0, 0, 1);
    chk("release_valid", rand_valid, 0);
    tick(0, 0, 0, 0, 0);
    chk("idle_valid", rand_valid, 0);
    // Asynchronous reset in the middle of a search
    do_reset();
    tick(0, 1, 62, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_q", lfsr_q, 0);
    chk("async_valid", rand_valid, 0);
    chk("async_out", rand_out, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(0, 0, 0, 0, 0);
    chk("post_reset_idle", {rand_valid, lfsr_q}, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
    chk("post_reset_valid", rand_valid, 1);
    chk("post_reset_out", rand_out, 0);
    chk("post_reset_q", lfsr_q, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
